// File: rtl/prime_check_arbiter.sv
// Round-robin shared trial-division prime checker: NREQ requesters, one engine.
// Latency: gnt the cycle after accept; result k+1 cycles later (k = divisors tried).
// Backpressure: one job at a time; other requests wait (held req) until the engine is IDLE.
module prime_check_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] number_flat,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done_valid,
    output logic [IDW-1:0]        done_id,
    output logic [WIDTH-1:0]      done_number,
    output logic                  is_prime
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_id;
    logic [WIDTH-1:0]    r_num;
    logic [WIDTH-1:0]    r_d;
    logic [NREQ-1:0]     r_gnt;
    logic                r_done_valid;
    logic [IDW-1:0]      r_done_id;
    logic [WIDTH-1:0]    r_done_number;
    logic                r_is_prime;
    logic [IDW-1:0]      w_winner;
    logic [2*WIDTH-1:0]  w_dsq;
    logic                w_accept;
    logic                w_finish;
    logic                w_prime;

    // First set request bit searching cyclically from p+1. Scanning from the
    // far end down lets the nearest hit overwrite the others.
    function automatic logic [IDW-1:0] f_rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [IDW-1:0]  p);
        logic [IDW-1:0] w;
        int             j;
        w = p;
        for (int i = NREQ; i >= 1; i--) begin
            j = int'(p) + i;
            if (j >= NREQ) j = j - NREQ;
            if (r[j[IDW-1:0]]) w = j[IDW-1:0];
        end
        return w;
    endfunction

    // Round-robin winner for the current request vector.
    always_comb begin
        w_winner = f_rr_pick(req, r_ptr);
    end

    // Full-width square so the d*d > num test can never overflow.
    assign w_dsq = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_d};

    // Next state and per-cycle decisions: accept in IDLE, one divisor per cycle in CHECK.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_prime     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_num <= WIDTH'(1)) begin
                    w_finish = 1'b1;
                end else if (w_dsq > {{WIDTH{1'b0}}, r_num}) begin
                    w_finish = 1'b1;
                    w_prime  = 1'b1;
                end else if ((r_num % r_d) == '0) begin
                    w_finish = 1'b1;
                end
                if (w_finish) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Job latch, divisor stepping, grant pulse and held result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr         <= IDW'(NREQ - 1);
            r_id          <= '0;
            r_num         <= '0;
            r_d           <= '0;
            r_gnt         <= '0;
            r_done_valid  <= 1'b0;
            r_done_id     <= '0;
            r_done_number <= '0;
            r_is_prime    <= 1'b0;
        end else begin
            r_gnt        <= '0;
            r_done_valid <= 1'b0;
            if (w_accept) begin
                r_num <= number_flat[int'(w_winner)*WIDTH +: WIDTH];
                r_id  <= w_winner;
                r_ptr <= w_winner;
                r_d   <= WIDTH'(2);
                r_gnt <= NREQ'(1) << w_winner;
            end
            if (r_state == S_CHECK) begin
                if (w_finish) begin
                    r_done_valid  <= 1'b1;
                    r_done_id     <= r_id;
                    r_done_number <= r_num;
                    r_is_prime    <= w_prime;
                end else begin
                    r_d <= r_d + WIDTH'(1);
                end
            end
        end
    end

    assign gnt         = r_gnt;
    assign busy        = (r_state != S_IDLE);
    assign done_valid  = r_done_valid;
    assign done_id     = r_done_id;
    assign done_number = r_done_number;
    assign is_prime    = r_is_prime;

endmodule

// File: tb/tb_prime_check_arbiter.sv
// Directed bench for prime_check_arbiter: grants, round-robin order, latency, reset abort.
// Samples outputs on the falling clock edge; drives inputs there too.
// Every wait on the DUT is bounded by a cycle budget.
module tb_prime_check_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   number_flat;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             done_valid;
    logic [IDW-1:0]   done_id;
    logic [W-1:0]     done_number;
    logic             is_prime;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] n;
        logic         p;
        int           k;
    } vec_t;

    prime_check_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .number_flat (number_flat),
        .gnt         (gnt),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_id     (done_id),
        .done_number (done_number),
        .is_prime    (is_prime)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_num(input int i, input logic [W-1:0] v);
        number_flat[i*W +: W] = v;
    endtask

    // Wait for a grant pulse; cyc = falling edges waited.
    task automatic wait_grant(input int exp_idx, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (gnt == '0 && cyc < 50);
        chk("gnt", gnt, 64'd1 << exp_idx);
        chk("busy_at_gnt", busy, 1);
    endtask

    // Count cycles from the grant cycle to done_valid and check the result.
    task automatic wait_done(input int exp_id, input logic [W-1:0] exp_num,
                             input logic exp_p, input int exp_k);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) chk("gnt_pulse", gnt, 0);
        end while (!done_valid && k < 3000);
        chk("done_valid", done_valid, 1);
        chk("k_cycles", k, exp_k);
        chk("done_id", done_id, exp_id);
        chk("done_number", done_number, exp_num);
        chk("is_prime", is_prime, exp_p);
        @(negedge clk);
        chk("done_pulse", done_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    // Single job on one requester; input is scrambled after grant.
    task automatic run_job(input int id, input logic [W-1:0] num,
                           input logic exp_p, input int exp_k);
        int c;
        set_num(id, num);
        req[id] = 1'b1;
        wait_grant(id, c);
        req[id] = 1'b0;
        set_num(id, ~num);
        wait_done(id, num, exp_p, exp_k);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t t2[7] = '{
        '{32'd0,  1'b0, 1}, '{32'd1,  1'b0, 1}, '{32'd4,  1'b0, 1},
        '{32'd9,  1'b0, 2}, '{32'd15, 1'b0, 2}, '{32'd11, 1'b1, 3},
        '{32'd29, 1'b1, 5}
    };
    vec_t t3[4] = '{
        '{32'd3, 1'b1, 1}, '{32'd5, 1'b1, 2}, '{32'd6, 1'b0, 1}, '{32'd7, 1'b1, 2}
    };
    vec_t t4[3] = '{
        '{32'd1000003, 1'b1, 1000}, '{32'd1000001, 1'b0, 100}, '{32'hFFFFFFFF, 1'b0, 2}
    };

    initial begin
        int c;
        rst_n       = 1'b0;
        req         = '0;
        number_flat = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_done_number", done_number, 0);
        chk("rst_is_prime", is_prime, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: smallest prime on requester 0
        run_job(0, 32'd2, 1'b1, 1);

        // T2: sequential jobs on requester 1
        foreach (t2[i]) run_job(1, t2[i].n, t2[i].p, t2[i].k);

        // T3: all four requesting right after reset, then 0101 with ptr=3
        do_reset();
        for (int i = 0; i < 4; i++) set_num(i, t3[i].n);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_grant(i, c);
            req[i] = 1'b0;
            wait_done(i, t3[i].n, t3[i].p, t3[i].k);
        end
        set_num(0, 32'd9);
        set_num(2, 32'd17);
        req = 4'b0101;
        wait_grant(0, c);
        req[0] = 1'b0;
        wait_done(0, 32'd9, 1'b0, 2);
        wait_grant(2, c);
        req[2] = 1'b0;
        wait_done(2, 32'd17, 1'b1, 4);

        // T4: long runs
        foreach (t4[i]) run_job(0, t4[i].n, t4[i].p, t4[i].k);

        // T5: reset mid-CHECK drops the job; pending req[2] then served
        set_num(0, 32'd1000003);
        req[0] = 1'b1;
        wait_grant(0, c);
        req[0] = 1'b0;
        set_num(2, 32'd7);
        req[2] = 1'b1;
        repeat (50) @(negedge clk);
        chk("mid_check_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_gnt", gnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done_valid", done_valid, 0);
        chk("abort_done_id", done_id, 0);
        chk("abort_done_number", done_number, 0);
        chk("abort_is_prime", is_prime, 0);
        rst_n = 1'b1;
        wait_grant(2, c);
        chk("t5_no_stray_done", c, 1);
        req[2] = 1'b0;
        wait_done(2, 32'd7, 1'b1, 2);

        // T6: req[3] held through its job; req[1] served before the re-grant
        set_num(3, 32'd13);
        set_num(1, 32'd25);
        req = 4'b1010;
        wait_grant(3, c);
        wait_done(3, 32'd13, 1'b1, 3);
        wait_grant(1, c);
        chk("t6_rr_gap", c, 1);
        req[1] = 1'b0;
        wait_done(1, 32'd25, 1'b0, 4);
        wait_grant(3, c);
        chk("t6_regrant_gap", c, 1);
        req[3] = 1'b0;
        wait_done(3, 32'd13, 1'b1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
